// File: rtl/dilithium_vy_loader_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dilithium_vy_loader_pkg
//  Brief    : Field/state encodings and per-security-level sizes for the
//             Dilithium verify loader.
//  Revision : 1.0
// ============================================================================
package dilithium_vy_loader_pkg;

    typedef enum logic [2:0] {
        F_RHO  = 3'd0,
        F_C    = 3'd1,
        F_Z    = 3'd2,
        F_T1   = 3'd3,
        F_MLEN = 3'd4,
        F_MSG  = 3'd5,
        F_H    = 3'd6
    } field_t;

    // Load states are contiguous so the next field is simply state + 1.
    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_RHO      = 4'd1,
        S_C        = 4'd2,
        S_Z        = 4'd3,
        S_T1       = 4'd4,
        S_MLEN     = 4'd5,
        S_MSG      = 4'd6,
        S_H        = 4'd7,
        S_WAIT_RES = 4'd8,
        S_RESULT   = 4'd9
    } state_t;

    localparam logic [1:0] C_MODE_VERIFY = 2'd1;
    localparam int         C_RHO_BITS    = 256;
    localparam int         C_C_BITS      = 256;

    function automatic int z_size(input int sec);
        return (sec == 5) ? 35840 : (sec == 3) ? 25600 : 18432;
    endfunction

    function automatic int t1_size(input int sec);
        return (sec == 5) ? 20480 : (sec == 3) ? 15360 : 10240;
    endfunction

    function automatic int h_size(input int sec);
        return (sec == 5) ? 664 : (sec == 3) ? 488 : 672;
    endfunction

    function automatic int words(input int bits, input int w);
        return (bits + w - 1) / w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dilithium_vy_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : dilithium_vy_loader
//  Brief    : Host front end for Dilithium verify: tags and forwards the
//             RHO/C/Z/T1/MLEN/MSG/H word stream, then returns the verdict.
//  Revision : 1.0
// ============================================================================
module dilithium_vy_loader
    import dilithium_vy_loader_pkg::*;
#(
    parameter int  HIGH_PERF = 1,
    parameter int  SEC_LEVEL = 2,
    parameter int  MLEN_W    = 16,
    localparam int W         = (HIGH_PERF != 0) ? 64 : 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              valid_i,
    output logic              ready_i,
    input  logic [W-1:0]      data_i,
    output logic              valid_o,
    input  logic              ready_o,
    output logic [W-1:0]      data_o,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [2:0]        wr_field,
    output logic [9:0]        wr_addr,
    output logic [W-1:0]      wr_data,
    output logic [MLEN_W-1:0] msg_len,
    input  logic              res_valid,
    input  logic              res_reject,
    output logic              busy
);

    localparam int C_LOG2W    = (HIGH_PERF != 0) ? 6 : 5;
    // Wide enough for the longest MSG field (msg_len*8/32 words) and for Z.
    localparam int C_CNT_W    = ((MLEN_W + 3) > 12) ? (MLEN_W + 3) : 12;
    localparam int C_RHO_WORDS = words(C_RHO_BITS, W);
    localparam int C_C_WORDS   = words(C_C_BITS, W);
    localparam int C_Z_WORDS   = words(z_size(SEC_LEVEL), W);
    localparam int C_T1_WORDS  = words(t1_size(SEC_LEVEL), W);
    localparam int C_H_WORDS   = words(h_size(SEC_LEVEL), W);

    state_t              r_state;
    logic [C_CNT_W-1:0]  r_cnt;
    logic [MLEN_W-1:0]   r_msg_len;
    logic                r_reject;
    logic                r_valid_o;

    logic                w_load;
    logic                w_xfer;
    logic                w_last;
    logic [C_CNT_W-1:0]  w_msg_ceil;
    logic [C_CNT_W-1:0]  w_limit;
    field_t              w_field;

    assign w_load = (r_state >= S_RHO) && (r_state <= S_H);
    assign w_xfer = w_load && valid_i && wr_ready;

    // ceil(msg_len*8/W): bytes-per-word is a power of two, so shift and round up.
    assign w_msg_ceil = C_CNT_W'(r_msg_len >> (C_LOG2W - 3))
                      + C_CNT_W'(|r_msg_len[C_LOG2W-4:0]);

    always_comb begin
        w_limit = C_CNT_W'(1);
        w_field = F_RHO;
        case (r_state)
            S_RHO:  begin w_limit = C_CNT_W'(C_RHO_WORDS); w_field = F_RHO;  end
            S_C:    begin w_limit = C_CNT_W'(C_C_WORDS);   w_field = F_C;    end
            S_Z:    begin w_limit = C_CNT_W'(C_Z_WORDS);   w_field = F_Z;    end
            S_T1:   begin w_limit = C_CNT_W'(C_T1_WORDS);  w_field = F_T1;   end
            S_MLEN: begin w_limit = C_CNT_W'(1);           w_field = F_MLEN; end
            S_MSG:  begin
                // An empty message still carries one (ignored) word.
                w_limit = (w_msg_ceil == '0) ? C_CNT_W'(1) : w_msg_ceil;
                w_field = F_MSG;
            end
            S_H:    begin w_limit = C_CNT_W'(C_H_WORDS);   w_field = F_H;    end
            default: begin w_limit = C_CNT_W'(1);          w_field = F_RHO;  end
        endcase
    end

    assign w_last = (r_cnt == (w_limit - C_CNT_W'(1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_msg_len <= '0;
            r_reject  <= 1'b0;
            r_valid_o <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && (mode == C_MODE_VERIFY)) begin
                        r_state <= S_RHO;
                        r_cnt   <= '0;
                    end
                end
                S_WAIT_RES: begin
                    if (res_valid) begin
                        r_reject  <= res_reject;
                        r_valid_o <= 1'b1;
                        r_state   <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (ready_o) begin
                        r_valid_o <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    if (w_xfer) begin
                        if (r_state == S_MLEN) begin
                            r_msg_len <= data_i[MLEN_W-1:0];
                        end
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= state_t'(r_state + 4'd1);
                        end else begin
                            r_cnt   <= r_cnt + C_CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign ready_i  = w_load && wr_ready;
    assign wr_valid = w_load && valid_i;
    assign wr_data  = data_i;
    assign wr_field = w_field;
    assign wr_addr  = r_cnt[9:0];
    assign msg_len  = r_msg_len;
    assign valid_o  = r_valid_o;
    assign data_o   = {{(W-1){1'b0}}, r_reject};
    assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire
